// File: rtl/mem_ctrl_stream.sv
// Dual-bank operand RAM controller: host load path and backpressured stream-out path.
// Optional MC_OPB_OFFSET_EN gives bank B its own base address and pointer.

// Small synchronous FIFO with an occupancy output.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: a push is dropped when full unless a pop happens in the same cycle.
module mem_ctrl_stream_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push_vld,
  input  logic [W-1:0]     i_push_dat,
  input  logic             i_pop_rdy,
  output logic             o_pop_vld,
  output logic [W-1:0]     o_pop_dat,
  output logic [PTR_W:0]   o_cnt
);
  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop_rdy & (r_cnt != '0);
  assign w_push = i_push_vld & ((r_cnt != (PTR_W+1)'(DEPTH)) | w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH-1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH-1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (PTR_W+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PTR_W+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_pop_vld = (r_cnt != '0);
  assign o_pop_dat = r_mem[r_rd_ptr];
  assign o_cnt     = r_cnt;
endmodule

// Loads host operand pairs into the RAM, later streams them out in address order.
// Latency: first pair valid 2 cycles after the read start is accepted; then 1 pair/cycle.
// Backpressure: host_data_ready in LOAD; stream-out stalls address issue on mc_op_ready low.
module mem_ctrl_stream #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 7
) (
  input  logic              mc_clk,
  input  logic              mc_rst_n,
  input  logic              host_start_load,
  input  logic              host_start_read,
  input  logic [ADDR_W-1:0] host_base_addr,
`ifdef MC_OPB_OFFSET_EN
  input  logic [ADDR_W-1:0] host_base_addr_opb,
`endif
  input  logic [CNT_W-1:0]  host_count,
  input  logic              host_data_valid,
  output logic              host_data_ready,
  input  logic [DATA_W-1:0] host_data_opa,
  input  logic [DATA_W-1:0] host_data_opb,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mc_address_mem_opa,
  output logic [ADDR_W-1:0] mc_address_mem_opb,
  output logic [DATA_W-1:0] mem_data_in_opa,
  output logic [DATA_W-1:0] mem_data_in_opb,
  input  logic [DATA_W-1:0] mem_data_out_opa,
  input  logic [DATA_W-1:0] mem_data_out_opb,
  output logic              mc_op_valid,
  input  logic              mc_op_ready,
  output logic [DATA_W-1:0] mc_opa,
  output logic [DATA_W-1:0] mc_opb,
  output logic              mc_busy,
  output logic              mc_done,
  output logic              mc_error
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr_a;
`ifdef MC_OPB_OFFSET_EN
  logic [ADDR_W-1:0] r_ptr_b;
`endif
  logic [CNT_W-1:0]  r_remaining;
  logic              r_inflight;
  logic              r_done;
  logic              r_error;

  logic              w_start;
  logic              w_cnt_bad;
  logic              w_beat;
  logic              w_pop;
  logic              w_issue;
  logic              w_last_pop;
  logic [1:0]        w_fifo_cnt;
  logic [2:0]        w_occupancy_next;
  logic              w_fifo_vld;
  logic [2*DATA_W-1:0] w_fifo_dat;

  assign w_start   = (r_state == S_IDLE) & (host_start_load | host_start_read);
  assign w_cnt_bad = (host_count == '0) || ({1'b0, host_count} > (CNT_W+1)'(DEPTH));
  assign w_beat    = (r_state == S_LOAD) & host_data_valid;
  assign w_pop     = w_fifo_vld & mc_op_ready;

  // Count the slot freed by a same-cycle pop so a steady ready stream sees no bubbles.
  assign w_occupancy_next = {1'b0, w_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue    = (r_state == S_READ) && (r_remaining != '0) && (w_occupancy_next < 3'd2);
  assign w_last_pop = (r_state == S_DRAIN) && w_pop && (w_fifo_cnt == 2'd1) && !r_inflight;

  always_ff @(posedge mc_clk or negedge mc_rst_n) begin
    if (!mc_rst_n) begin
      r_state     <= S_IDLE;
      r_ptr_a     <= '0;
`ifdef MC_OPB_OFFSET_EN
      r_ptr_b     <= '0;
`endif
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_error     <= w_cnt_bad;
            r_ptr_a     <= host_base_addr;
`ifdef MC_OPB_OFFSET_EN
            r_ptr_b     <= host_base_addr_opb;
`endif
            r_remaining <= host_count;
            if (!w_cnt_bad) r_state <= host_start_load ? S_LOAD : S_READ;
          end
        end
        S_LOAD: begin
          if (w_beat) begin
            r_ptr_a     <= r_ptr_a + ADDR_W'(1);
`ifdef MC_OPB_OFFSET_EN
            r_ptr_b     <= r_ptr_b + ADDR_W'(1);
`endif
            r_remaining <= r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (w_issue) begin
            r_ptr_a     <= r_ptr_a + ADDR_W'(1);
`ifdef MC_OPB_OFFSET_EN
            r_ptr_b     <= r_ptr_b + ADDR_W'(1);
`endif
            r_remaining <= r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_last_pop) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The RAM returns data one cycle after the address, which is exactly when r_inflight is set.
  mem_ctrl_stream_fifo #(
    .W     (2*DATA_W),
    .DEPTH (2)
  ) u_out_fifo (
    .i_clk      (mc_clk),
    .i_rst_n    (mc_rst_n),
    .i_push_vld (r_inflight),
    .i_push_dat ({mem_data_out_opa, mem_data_out_opb}),
    .i_pop_rdy  (mc_op_ready),
    .o_pop_vld  (w_fifo_vld),
    .o_pop_dat  (w_fifo_dat),
    .o_cnt      (w_fifo_cnt)
  );

  assign host_data_ready    = (r_state == S_LOAD);
  assign mem_we             = w_beat;
  assign mem_data_in_opa    = (r_state == S_LOAD) ? host_data_opa : '0;
  assign mem_data_in_opb    = (r_state == S_LOAD) ? host_data_opb : '0;
  assign mc_address_mem_opa = r_ptr_a;
`ifdef MC_OPB_OFFSET_EN
  assign mc_address_mem_opb = r_ptr_b;
`else
  assign mc_address_mem_opb = r_ptr_a;
`endif
  assign mc_op_valid        = w_fifo_vld;
  assign mc_opa             = w_fifo_dat[2*DATA_W-1:DATA_W];
  assign mc_opb             = w_fifo_dat[DATA_W-1:0];
  assign mc_busy            = (r_state != S_IDLE);
  assign mc_done            = r_done;
  assign mc_error           = r_error;
endmodule

// File: tb/tb_mem_ctrl_stream.sv
// Directed bench for mem_ctrl_stream with a behavioural dual-bank RAM and write/read scoreboards.
module tb_mem_ctrl_stream;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 7;

  logic              mc_clk = 1'b0;
  logic              mc_rst_n = 1'b0;
  logic              host_start_load = 1'b0;
  logic              host_start_read = 1'b0;
  logic [ADDR_W-1:0] host_base_addr = '0;
  logic [CNT_W-1:0]  host_count = '0;
  logic              host_data_valid = 1'b0;
  logic              host_data_ready;
  logic [DATA_W-1:0] host_data_opa = '0;
  logic [DATA_W-1:0] host_data_opb = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mc_address_mem_opa;
  logic [ADDR_W-1:0] mc_address_mem_opb;
  logic [DATA_W-1:0] mem_data_in_opa;
  logic [DATA_W-1:0] mem_data_in_opb;
  logic [DATA_W-1:0] mem_data_out_opa = '0;
  logic [DATA_W-1:0] mem_data_out_opb = '0;
  logic              mc_op_valid;
  logic              mc_op_ready = 1'b0;
  logic [DATA_W-1:0] mc_opa;
  logic [DATA_W-1:0] mc_opb;
  logic              mc_busy;
  logic              mc_done;
  logic              mc_error;

  int errors = 0;
  int checks = 0;
  int done_count = 0;
  int we_count = 0;
  int done_snap;
  int we_snap;

  logic [ADDR_W-1:0] wq_addr[$];
  logic [DATA_W-1:0] wq_a[$];
  logic [DATA_W-1:0] wq_b[$];
  logic [DATA_W-1:0] rq_a[$];
  logic [DATA_W-1:0] rq_b[$];

  logic [DATA_W-1:0] ram_a [64];
  logic [DATA_W-1:0] ram_b [64];

  always #5 mc_clk = ~mc_clk;

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram_a[i] = '0;
      ram_b[i] = '0;
    end
  end

  always @(posedge mc_clk) begin
    if (mem_we) begin
      ram_a[mc_address_mem_opa] <= mem_data_in_opa;
      ram_b[mc_address_mem_opb] <= mem_data_in_opb;
    end
    mem_data_out_opa <= ram_a[mc_address_mem_opa];
    mem_data_out_opb <= ram_b[mc_address_mem_opb];
  end

  mem_ctrl_stream #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .mc_clk             (mc_clk),
    .mc_rst_n           (mc_rst_n),
    .host_start_load    (host_start_load),
    .host_start_read    (host_start_read),
    .host_base_addr     (host_base_addr),
`ifdef MC_OPB_OFFSET_EN
    .host_base_addr_opb (host_base_addr),
`endif
    .host_count         (host_count),
    .host_data_valid    (host_data_valid),
    .host_data_ready    (host_data_ready),
    .host_data_opa      (host_data_opa),
    .host_data_opb      (host_data_opb),
    .mem_we             (mem_we),
    .mc_address_mem_opa (mc_address_mem_opa),
    .mc_address_mem_opb (mc_address_mem_opb),
    .mem_data_in_opa    (mem_data_in_opa),
    .mem_data_in_opb    (mem_data_in_opb),
    .mem_data_out_opa   (mem_data_out_opa),
    .mem_data_out_opb   (mem_data_out_opb),
    .mc_op_valid        (mc_op_valid),
    .mc_op_ready        (mc_op_ready),
    .mc_opa             (mc_opa),
    .mc_opb             (mc_opb),
    .mc_busy            (mc_busy),
    .mc_done            (mc_done),
    .mc_error           (mc_error)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks this cycle's outputs against the scoreboards, then advances to the next negedge.
  task automatic tick();
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] da;
    logic [DATA_W-1:0] db;
    #1;
    if (mc_done) done_count++;
    if (mem_we) begin
      we_count++;
      chk("wr_queue_nonempty", wq_addr.size() != 0, 1);
      if (wq_addr.size() != 0) begin
        ea = wq_addr.pop_front();
        da = wq_a.pop_front();
        db = wq_b.pop_front();
        chk("wr_addr_a", mc_address_mem_opa, ea);
        chk("wr_addr_b", mc_address_mem_opb, ea);
        chk("wr_data_a", mem_data_in_opa, da);
        chk("wr_data_b", mem_data_in_opb, db);
      end
    end
    if (mc_op_valid && mc_op_ready) begin
      chk("rd_queue_nonempty", rq_a.size() != 0, 1);
      if (rq_a.size() != 0) begin
        da = rq_a.pop_front();
        db = rq_b.pop_front();
        chk("rd_opa", mc_opa, da);
        chk("rd_opb", mc_opb, db);
      end
    end
    @(negedge mc_clk);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (!mc_done && n < budget) begin
      tick();
      n++;
    end
    chk(tag, mc_done, 1);
  endtask

  task automatic start(input logic is_load, input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt);
    host_base_addr  = base;
    host_count      = cnt;
    host_start_load = is_load;
    host_start_read = !is_load;
    tick();
    host_start_load = 1'b0;
    host_start_read = 1'b0;
  endtask

  task automatic load_beats(input logic [ADDR_W-1:0] base, input int n, input logic [DATA_W-1:0] a0,
                            input logic [DATA_W-1:0] b0);
    for (int i = 0; i < n; i++) begin
      host_data_valid = 1'b1;
      host_data_opa   = a0 + DATA_W'(i);
      host_data_opb   = b0 + DATA_W'(i);
      wq_addr.push_back(base + ADDR_W'(i));
      wq_a.push_back(a0 + DATA_W'(i));
      wq_b.push_back(b0 + DATA_W'(i));
      tick();
    end
    host_data_valid = 1'b0;
  endtask

  task automatic expect_reads(input int first, input int n, input logic [DATA_W-1:0] a0,
                              input logic [DATA_W-1:0] b0);
    for (int i = first; i < first + n; i++) begin
      rq_a.push_back(a0 + DATA_W'(i));
      rq_b.push_back(b0 + DATA_W'(i));
    end
  endtask

  initial begin
    @(negedge mc_clk);
    @(negedge mc_clk);
    chk("rst_we", mem_we, 0);
    chk("rst_ready", host_data_ready, 0);
    chk("rst_valid", mc_op_valid, 0);
    chk("rst_busy", mc_busy, 0);
    chk("rst_done", mc_done, 0);
    chk("rst_error", mc_error, 0);
    chk("rst_addr_a", mc_address_mem_opa, 0);
    chk("rst_addr_b", mc_address_mem_opb, 0);
    chk("rst_din_a", mem_data_in_opa, 0);
    chk("rst_opa", mc_opa, 0);
    mc_rst_n = 1'b1;
    @(negedge mc_clk);

    // Load 4 pairs at base 5.
    we_snap = we_count;
    start(1'b1, 6'd5, 7'd4);
    chk("load_busy", mc_busy, 1);
    chk("load_ready", host_data_ready, 1);
    load_beats(6'd5, 4, 128'hA0, 128'hB0);
    chk("load_done", mc_done, 1);
    chk("load_idle", mc_busy, 0);
    chk("load_we_cycles", we_count - we_snap, 4);
    tick();
    chk("load_done_pulse", mc_done, 0);

    // Read 4 from base 5 with ready high: latency and back-to-back delivery.
    mc_op_ready = 1'b1;
    expect_reads(0, 4, 128'hA0, 128'hB0);
    start(1'b0, 6'd5, 7'd4);
    chk("rd_lat_c1", mc_op_valid, 0);
    tick();
    chk("rd_lat_c2", mc_op_valid, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("rd_stream_valid", mc_op_valid, 1);
      tick();
    end
    chk("rd_done", mc_done, 1);
    chk("rd_queue_empty", rq_a.size(), 0);

    // Read 3 with ready held low for 5 cycles after the first valid.
    mc_op_ready = 1'b0;
    expect_reads(0, 3, 128'hA0, 128'hB0);
    start(1'b0, 6'd5, 7'd3);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", mc_op_valid, 1);
      chk("stall_opa", mc_opa, 128'hA0);
      chk("stall_opb", mc_opb, 128'hB0);
      chk("stall_addr", mc_address_mem_opa, 7);
      tick();
    end
    mc_op_ready = 1'b1;
    wait_done(12, "stall_done");
    chk("stall_queue_empty", rq_a.size(), 0);
    tick();

    // Load and read back across the 63 -> 0 wrap.
    start(1'b1, 6'd62, 7'd3);
    load_beats(6'd62, 3, 128'hC0, 128'hD0);
    chk("wrap_load_done", mc_done, 1);
    expect_reads(0, 3, 128'hC0, 128'hD0);
    start(1'b0, 6'd62, 7'd3);
    wait_done(12, "wrap_rd_done");
    chk("wrap_queue_empty", rq_a.size(), 0);
    tick();

    // Illegal counts: sticky error, no busy, no done; a legal start clears it.
    done_snap = done_count;
    start(1'b1, 6'd3, 7'd0);
    chk("cnt0_error", mc_error, 1);
    chk("cnt0_busy", mc_busy, 0);
    chk("cnt0_ready", host_data_ready, 0);
    tick();
    tick();
    start(1'b0, 6'd3, 7'd65);
    chk("cnt65_error", mc_error, 1);
    chk("cnt65_busy", mc_busy, 0);
    tick();
    tick();
    chk("illegal_no_done", done_count - done_snap, 0);
    expect_reads(0, 1, 128'hC0, 128'hD0);
    start(1'b0, 6'd62, 7'd1);
    chk("legal_clears_error", mc_error, 0);
    wait_done(10, "legal_rd_done");
    chk("legal_queue_empty", rq_a.size(), 0);
    tick();

    // Asynchronous reset mid-READ with a pair buffered.
    mc_op_ready = 1'b0;
    start(1'b0, 6'd5, 7'd4);
    tick();
    tick();
    chk("pre_rst_valid", mc_op_valid, 1);
    mc_rst_n = 1'b0;
    #2;
    chk("arst_valid", mc_op_valid, 0);
    chk("arst_busy", mc_busy, 0);
    chk("arst_opa", mc_opa, 0);
    chk("arst_addr", mc_address_mem_opa, 0);
    @(negedge mc_clk);
    mc_rst_n = 1'b1;
    @(negedge mc_clk);
    mc_op_ready = 1'b1;
    expect_reads(2, 2, 128'hA0, 128'hB0);
    start(1'b0, 6'd7, 7'd2);
    wait_done(10, "post_rst_done");
    chk("post_rst_queue_empty", rq_a.size(), 0);
    tick();

    chk("wr_queue_drained", wq_addr.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_ctrl_stream.md
Name: mem_ctrl_stream

Overview:
- Memory controller directly upstream of the dual-bank operand RAM (64 x 128-bit per bank, synchronous write, registered read with 1-cycle latency, no read enable).
- Loads operand pairs from a host stream into the RAM.
- Later streams operand pairs back out to the execution datapath with valid/ready backpressure.
- Owns all RAM address and write-enable generation and hides the RAM read latency behind a 2-entry output buffer.

Parameters:
- ADDR_W, 6, RAM address width; depth = 2**ADDR_W = 64.
- DATA_W, 128, operand width per bank.
- CNT_W, 7, width of the transfer count; legal count is 1..2**ADDR_W.

Ports:
- mc_clk  in  1  single clock, rising edge.
- mc_rst_n  in  1  asynchronous active-low reset.
- host_start_load  in  1  pulse: begin load of host_count pairs at host_base_addr.
- host_start_read  in  1  pulse: begin stream-out of host_count pairs from host_base_addr.
- host_base_addr  in  ADDR_W  start address, sampled on an accepted start.
- host_count  in  CNT_W  number of pairs, sampled on an accepted start.
- host_data_valid  in  1  host write beat valid.
- host_data_ready  out  1  controller accepts a write beat.
- host_data_opa, host_data_opb  in  DATA_W  write operands.
- mem_we  out  1  RAM write enable.
- mc_address_mem_opa, mc_address_mem_opb  out  ADDR_W  RAM addresses.
- mem_data_in_opa, mem_data_in_opb  out  DATA_W  RAM write data.
- mem_data_out_opa, mem_data_out_opb  in  DATA_W  RAM registered read data.
- mc_op_valid  out  1  operand pair available downstream.
- mc_op_ready  in  1  downstream accepts the pair.
- mc_opa, mc_opb  out  DATA_W  operand pair to the datapath.
- mc_busy  out  1  high in any state other than IDLE.
- mc_done  out  1  one-cycle pulse on completion.
- mc_error  out  1  sticky flag; set on an illegal count, cleared by the next accepted start.

Behaviour:
- Reset values: state IDLE, pointer 0, remaining 0, FIFO empty, in-flight 0; all outputs 0.
  - mem_we, host_data_ready, mc_op_valid, mc_busy, mc_done, mc_error = 0.
  - Address and data outputs = 0.
- FSM states: IDLE, LOAD, READ, DRAIN.
- Starts are accepted only in IDLE; they are ignored while busy. If both starts are high in IDLE, load wins.
- An accepted start latches ptr = host_base_addr and remaining = host_count.
  - If host_count == 0 or host_count > 64: set mc_error, stay IDLE, no mc_done.
- LOAD:
  - host_data_ready = 1.
  - mem_we = host_data_valid (combinational); both addresses = ptr; mem_data_in = host data (combinational).
  - On each beat: ptr = ptr+1 mod 64 (wraps 63 -> 0); remaining decrements.
  - On the last beat: mc_done pulses the next cycle and the FSM returns to IDLE.
- READ:
  - Address ptr is issued in a cycle when (FIFO occupancy + in-flight) < 2 and remaining > 0. That cycle sets in-flight, advances ptr mod 64, and decrements remaining.
  - The RAM output in the following cycle is pushed into the 2-entry FIFO.
  - When remaining reaches 0, go to DRAIN.
  - mem_we = 0 throughout READ and DRAIN.
- DRAIN: when the last pair is popped (mc_op_valid & mc_op_ready), pulse mc_done the next cycle and go to IDLE.
- Downstream:
  - mc_op_valid = FIFO not empty; mc_opa/mc_opb = FIFO head.
  - Pop on valid & ready.
  - Pairs are delivered in address order.
  - A held-off pair must keep valid and data stable until accepted.
  - With ready held high, throughput is 1 pair per cycle after the first.
- Latency: the first pair is valid 2 cycles after start acceptance (cycle 1: issue address; cycle 2: RAM data registered; cycle 3: FIFO output valid).
- Simultaneous FIFO push and pop is legal and leaves occupancy unchanged.
- Asynchronous reset mid-operation: immediately return to reset values; FIFO is flushed; RAM contents are untouched.

Optional Feature:
- MC_OPB_OFFSET_EN defined:
  - Adds input host_base_addr_opb (ADDR_W), latched on start.
  - Bank B gets its own pointer, advancing and wrapping independently.
- Not defined: the port is absent and mc_address_mem_opb equals mc_address_mem_opa at all times.

Test Plan:
- Load 4 pairs at base 5 (opa = 0xA0..A3, opb = 0xB0..B3), host valid every cycle -> mem_we high 4 cycles at addresses 5,6,7,8; mc_done pulse 1 cycle after the last beat.
- Read count 4 from base 5 with mc_op_ready = 1 -> mc_op_valid 2 cycles after start; pairs (A0,B0)..(A3,B3) on consecutive cycles; mc_done after the 4th pop.
- Read count 3 with mc_op_ready low for 5 cycles after first valid -> (A0,B0) held stable, no address issued beyond 2 outstanding, no data loss, correct order on release.
- Load count 3 at base 62 -> write addresses 62, 63, 0; readback of 3 from base 62 returns the same data.
- host_count 0, then 65 -> mc_error set, mc_busy stays 0, no mc_done; next legal start clears mc_error.
- Assert mc_rst_n low mid-READ with 1 pair buffered -> mc_op_valid, mc_busy, FIFO cleared asynchronously; a new read after reset returns correct data.
